jzjpcc_execute: RTL and testbench

- Execute stage: consumes the decode→execute pipeline register fields and computes the ALU or iterative M-extension result.
- Applies late bypass from the hazard unit.
- Latches results into the execute→memory pipeline register.
- Multi-cycle mul/div holds the front of the pipe via stall_execute and feeds bubbles to memory while busy.

---
 rtl/jzjpcc_execute.sv | 213 +++++++++++++++++++++
 tb/tb_jzjpcc_execute.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_execute.sv
// Execute stage: single-cycle RV32I ALU plus an iterative radix-2 RV32M unit that
// stalls the front of the pipe and sends bubbles to memory while it works.
module jzjpcc_execute #(
  parameter int PC_MAX_B = 31
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rdWriteEnable_execute,
  input  logic                memoryWriteEnable_execute,
  input  logic [2:0]          aluOperation_execute,
  input  logic                aluMod_execute,
  input  logic [1:0]          aluMuxMode_execute,
  input  logic                mulDiv_execute,
  input  logic                rdSource_execute,
  input  logic [4:0]          rdAddr_execute,
  input  logic [2:0]          funct3_execute,
  input  logic [31:0]         immediate_execute,
  input  logic [PC_MAX_B:2]   currentPC_execute,
  input  logic [31:0]         rs1_execute,
  input  logic [31:0]         rs2_execute,
  input  logic                bypassRS1_execute,
  input  logic                bypassRS2_execute,
  input  logic [31:0]         bypassValueRS1_execute,
  input  logic [31:0]         bypassValueRS2_execute,
  output logic [31:0]         aluResult_memory,
  output logic [31:0]         rs2_memory,
  output logic [4:0]          rdAddr_memory,
  output logic [2:0]          funct3_memory,
  output logic                rdSource_memory,
  output logic                rdWriteEnable_memory,
  output logic                memoryWriteEnable_memory,
  output logic                stall_execute
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_count;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_negA;
  logic        r_negB;
  logic        r_divZero;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_rdSource;

  logic [31:0] w_realRS1;
  logic [31:0] w_realRS2;
  logic [31:0] w_pc32;
  logic [31:0] w_opA;
  logic [31:0] w_opB;
  logic [4:0]  w_shamt;
  logic [31:0] w_aluResult;
  logic        w_startMulDiv;
  logic        w_signedA;
  logic        w_signedB;
  logic        w_negA;
  logic        w_negB;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_mulSum;
  logic [63:0] w_mulNext;
  logic [32:0] w_divShift;
  logic [33:0] w_divDiff;
  logic [63:0] w_divNext;
  logic [63:0] w_mulProd;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_mdResult;

  assign w_realRS1 = bypassRS1_execute ? bypassValueRS1_execute : rs1_execute;
  assign w_realRS2 = bypassRS2_execute ? bypassValueRS2_execute : rs2_execute;

  always_comb begin
    w_pc32 = '0;
    w_pc32[PC_MAX_B:2] = currentPC_execute;
  end

  always_comb begin
    w_opA = w_realRS1;
    w_opB = w_realRS2;
    case (aluMuxMode_execute)
      2'b00: begin w_opA = w_realRS1; w_opB = w_realRS2;         end
      2'b01: begin w_opA = w_realRS1; w_opB = immediate_execute; end
      2'b10: begin w_opA = w_pc32;    w_opB = immediate_execute; end
      default: begin w_opA = 32'd0;   w_opB = immediate_execute; end
    endcase
  end

  assign w_shamt = w_opB[4:0];

  always_comb begin
    w_aluResult = '0;
    case (aluOperation_execute)
      3'b000: w_aluResult = aluMod_execute ? (w_opA - w_opB) : (w_opA + w_opB);
      3'b001: w_aluResult = w_opA << w_shamt;
      3'b010: w_aluResult = {31'd0, $signed(w_opA) < $signed(w_opB)};
      3'b011: w_aluResult = {31'd0, w_opA < w_opB};
      3'b100: w_aluResult = w_opA ^ w_opB;
      3'b101: w_aluResult = aluMod_execute ? 32'($signed(w_opA) >>> w_shamt) : (w_opA >> w_shamt);
      3'b110: w_aluResult = w_opA | w_opB;
      default: w_aluResult = w_opA & w_opB;
    endcase
  end

  // Operands are reduced to magnitudes up front; signs are reapplied in DONE.
  assign w_startMulDiv = (r_state == ST_IDLE) && mulDiv_execute && rdWriteEnable_execute;
  assign w_signedA = (funct3_execute == 3'b001) || (funct3_execute == 3'b010) ||
                     (funct3_execute == 3'b100) || (funct3_execute == 3'b110);
  assign w_signedB = (funct3_execute == 3'b001) || (funct3_execute == 3'b100) ||
                     (funct3_execute == 3'b110);
  assign w_negA = w_signedA && w_realRS1[31];
  assign w_negB = w_signedB && w_realRS2[31];
  assign w_absA = w_negA ? (32'd0 - w_realRS1) : w_realRS1;
  assign w_absB = w_negB ? (32'd0 - w_realRS2) : w_realRS2;

  // r_acc doubles as {partial product, multiplier} or {remainder, quotient}.
  assign w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mulNext  = {w_mulSum, r_acc[31:1]};
  assign w_divShift = {r_acc[63:32], r_acc[31]};
  assign w_divDiff  = {1'b0, w_divShift} - {2'b00, r_opnd};
  assign w_divNext  = w_divDiff[33] ? {w_divShift[31:0], r_acc[30:0], 1'b0}
                                    : {w_divDiff[31:0],  r_acc[30:0], 1'b1};

  assign w_mulProd = (r_negA ^ r_negB) ? (64'd0 - r_acc) : r_acc;
  assign w_quot    = r_divZero ? 32'hFFFF_FFFF
                               : ((r_negA ^ r_negB) ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
  assign w_rem     = r_negA ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_comb begin
    w_mdResult = '0;
    case (r_f3)
      3'b000:                 w_mdResult = w_mulProd[31:0];
      3'b001, 3'b010, 3'b011: w_mdResult = w_mulProd[63:32];
      3'b100, 3'b101:         w_mdResult = w_quot;
      default:                w_mdResult = w_rem;
    endcase
  end

  assign stall_execute = !reset && (w_startMulDiv || (r_state == ST_RUN));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state                  <= ST_IDLE;
      r_count                  <= '0;
      r_acc                    <= '0;
      r_opnd                   <= '0;
      r_negA                   <= 1'b0;
      r_negB                   <= 1'b0;
      r_divZero                <= 1'b0;
      r_f3                     <= '0;
      r_rd                     <= '0;
      r_rdSource               <= 1'b0;
      aluResult_memory         <= '0;
      rs2_memory               <= '0;
      rdAddr_memory            <= '0;
      funct3_memory            <= '0;
      rdSource_memory          <= 1'b0;
      rdWriteEnable_memory     <= 1'b0;
      memoryWriteEnable_memory <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startMulDiv) begin
            r_state                  <= ST_RUN;
            r_count                  <= '0;
            r_acc                    <= {32'd0, w_absA};
            r_opnd                   <= w_absB;
            r_negA                   <= w_negA;
            r_negB                   <= w_negB;
            r_divZero                <= (w_realRS2 == 32'd0);
            r_f3                     <= funct3_execute;
            r_rd                     <= rdAddr_execute;
            r_rdSource               <= rdSource_execute;
            rdWriteEnable_memory     <= 1'b0;
            memoryWriteEnable_memory <= 1'b0;
          end else begin
            aluResult_memory         <= w_aluResult;
            rs2_memory               <= w_realRS2;
            rdAddr_memory            <= rdAddr_execute;
            funct3_memory            <= funct3_execute;
            rdSource_memory          <= rdSource_execute;
            rdWriteEnable_memory     <= rdWriteEnable_execute;
            memoryWriteEnable_memory <= memoryWriteEnable_execute;
          end
        end
        ST_RUN: begin
          r_acc   <= r_f3[2] ? w_divNext : w_mulNext;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state <= ST_DONE;
          end
          rdWriteEnable_memory     <= 1'b0;
          memoryWriteEnable_memory <= 1'b0;
        end
        ST_DONE: begin
          aluResult_memory         <= w_mdResult;
          rdAddr_memory            <= r_rd;
          funct3_memory            <= r_f3;
          rdSource_memory          <= r_rdSource;
          rdWriteEnable_memory     <= 1'b1;
          memoryWriteEnable_memory <= 1'b0;
          r_state                  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jzjpcc_execute.sv
// Directed testbench for the execute stage: ALU ops, bypass, iterative mul/div
// timing and results, and asynchronous reset during an iterative operation.
module tb_jzjpcc_execute;

  logic              clock;
  logic              reset;
  logic              rdWriteEnable_execute;
  logic              memoryWriteEnable_execute;
  logic [2:0]        aluOperation_execute;
  logic              aluMod_execute;
  logic [1:0]        aluMuxMode_execute;
  logic              mulDiv_execute;
  logic              rdSource_execute;
  logic [4:0]        rdAddr_execute;
  logic [2:0]        funct3_execute;
  logic [31:0]       immediate_execute;
  logic [31:2]       currentPC_execute;
  logic [31:0]       rs1_execute;
  logic [31:0]       rs2_execute;
  logic              bypassRS1_execute;
  logic              bypassRS2_execute;
  logic [31:0]       bypassValueRS1_execute;
  logic [31:0]       bypassValueRS2_execute;
  logic [31:0]       aluResult_memory;
  logic [31:0]       rs2_memory;
  logic [4:0]        rdAddr_memory;
  logic [2:0]        funct3_memory;
  logic              rdSource_memory;
  logic              rdWriteEnable_memory;
  logic              memoryWriteEnable_memory;
  logic              stall_execute;

  int compared;
  int mismatched;

  jzjpcc_execute #(.PC_MAX_B(31)) dut (
    .clock(clock),
    .reset(reset),
    .rdWriteEnable_execute(rdWriteEnable_execute),
    .memoryWriteEnable_execute(memoryWriteEnable_execute),
    .aluOperation_execute(aluOperation_execute),
    .aluMod_execute(aluMod_execute),
    .aluMuxMode_execute(aluMuxMode_execute),
    .mulDiv_execute(mulDiv_execute),
    .rdSource_execute(rdSource_execute),
    .rdAddr_execute(rdAddr_execute),
    .funct3_execute(funct3_execute),
    .immediate_execute(immediate_execute),
    .currentPC_execute(currentPC_execute),
    .rs1_execute(rs1_execute),
    .rs2_execute(rs2_execute),
    .bypassRS1_execute(bypassRS1_execute),
    .bypassRS2_execute(bypassRS2_execute),
    .bypassValueRS1_execute(bypassValueRS1_execute),
    .bypassValueRS2_execute(bypassValueRS2_execute),
    .aluResult_memory(aluResult_memory),
    .rs2_memory(rs2_memory),
    .rdAddr_memory(rdAddr_memory),
    .funct3_memory(funct3_memory),
    .rdSource_memory(rdSource_memory),
    .rdWriteEnable_memory(rdWriteEnable_memory),
    .memoryWriteEnable_memory(memoryWriteEnable_memory),
    .stall_execute(stall_execute)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clearInputs;
    rdWriteEnable_execute     = 1'b0;
    memoryWriteEnable_execute = 1'b0;
    aluOperation_execute      = 3'b000;
    aluMod_execute            = 1'b0;
    aluMuxMode_execute        = 2'b00;
    mulDiv_execute            = 1'b0;
    rdSource_execute          = 1'b0;
    rdAddr_execute            = 5'd0;
    funct3_execute            = 3'b000;
    immediate_execute         = 32'd0;
    currentPC_execute         = '0;
    rs1_execute               = 32'd0;
    rs2_execute               = 32'd0;
    bypassRS1_execute         = 1'b0;
    bypassRS2_execute         = 1'b0;
    bypassValueRS1_execute    = 32'd0;
    bypassValueRS2_execute    = 32'd0;
  endtask

  task automatic stepCycle;
    @(posedge clock);
    #1;
  endtask

  task automatic driveAlu(input logic [2:0] op, input logic mod, input logic [1:0] mux,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    clearInputs();
    rdWriteEnable_execute = 1'b1;
    rdAddr_execute        = 5'd3;
    aluOperation_execute  = op;
    funct3_execute        = op;
    aluMod_execute        = mod;
    aluMuxMode_execute    = mux;
    rs1_execute           = a;
    rs2_execute           = b;
    immediate_execute     = imm;
  endtask

  // Runs one mul/div op from its entry cycle to the edge that latches its result.
  task automatic runMulDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int stallCycles, output bit bubbleOk, output bit timedOut);
    clearInputs();
    mulDiv_execute        = 1'b1;
    rdWriteEnable_execute = 1'b1;
    rdAddr_execute        = 5'd5;
    funct3_execute        = f3;
    rs1_execute           = a;
    rs2_execute           = b;
    stallCycles = 0;
    bubbleOk    = 1'b1;
    timedOut    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!stall_execute) begin
        timedOut = 1'b0;
        break;
      end
      stallCycles++;
      stepCycle();
      if (rdWriteEnable_memory !== 1'b0 || memoryWriteEnable_memory !== 1'b0) bubbleOk = 1'b0;
    end
    stepCycle();
    clearInputs();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clearInputs();
    mulDiv_execute        = 1'b1;
    rdWriteEnable_execute = 1'b1;
    repeat (2) stepCycle();
    compared++;
    if (aluResult_memory !== 32'd0 || rdWriteEnable_memory !== 1'b0 || rdAddr_memory !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got alu=%h rdWE=%b rd=%0d, want 0/0/0",
               aluResult_memory, rdWriteEnable_memory, rdAddr_memory);
    end
    compared++;
    if (stall_execute !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_stall: got %b want 0", stall_execute);
    end
    clearInputs();
    @(negedge clock);
    reset = 1'b0;
    stepCycle();
  endtask

  task automatic test_add;
    driveAlu(3'b000, 1'b0, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFD);
    @(negedge clock);
    compared++;
    if (stall_execute !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_stall: got %b want 0", stall_execute);
    end
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'd2 || rdWriteEnable_memory !== 1'b1 || rdAddr_memory !== 5'd3) begin
      mismatched++;
      $display("[TB] FAIL add_result: got alu=%h rdWE=%b rd=%0d, want 00000002/1/3",
               aluResult_memory, rdWriteEnable_memory, rdAddr_memory);
    end
  endtask

  task automatic test_shift_lui_auipc;
    driveAlu(3'b101, 1'b1, 2'b00, 32'h8000_0000, 32'd4, 32'd0);
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'hF800_0000) begin
      mismatched++;
      $display("[TB] FAIL sra: got %h want f8000000", aluResult_memory);
    end
    driveAlu(3'b000, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000);
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'h1234_5000) begin
      mismatched++;
      $display("[TB] FAIL lui: got %h want 12345000", aluResult_memory);
    end
    driveAlu(3'b000, 1'b0, 2'b10, 32'hDEAD_BEEF, 32'd0, 32'h0000_1000);
    currentPC_execute = 30'h100;
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'h0000_1400) begin
      mismatched++;
      $display("[TB] FAIL auipc: got %h want 00001400", aluResult_memory);
    end
  endtask

  task automatic test_alu_ops;
    logic [2:0]  ops  [8];
    logic        mods [8];
    logic [31:0] as   [8];
    logic [31:0] bs   [8];
    logic [31:0] exps [8];
    ops = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    mods = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    as  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_F0F0, 32'h8000_0000, 32'hF000_0000, 32'hFF00_FF00};
    bs  = '{32'd7, 32'd1, 32'd1, 32'd31, 32'h0FF0_0FF0, 32'd4, 32'h0000_000F, 32'h0FF0_0FF0};
    exps = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'h8000_0000, 32'hFF00_FF00, 32'h0800_0000, 32'hF000_000F, 32'h0F00_0F00};
    for (int i = 0; i < 8; i++) begin
      driveAlu(ops[i], mods[i], 2'b00, as[i], bs[i], 32'd0);
      stepCycle();
      compared++;
      if (aluResult_memory !== exps[i]) begin
        mismatched++;
        $display("[TB] FAIL alu_op%0d: got %h want %h", i, aluResult_memory, exps[i]);
      end
    end
  endtask

  task automatic test_bypass;
    driveAlu(3'b000, 1'b0, 2'b00, 32'd1, 32'h20, 32'd0);
    bypassRS1_execute      = 1'b1;
    bypassValueRS1_execute = 32'h10;
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'h30) begin
      mismatched++;
      $display("[TB] FAIL bypass_rs1: got %h want 00000030", aluResult_memory);
    end
    driveAlu(3'b000, 1'b0, 2'b01, 32'h100, 32'h20, 32'd4);
    rdWriteEnable_execute     = 1'b0;
    memoryWriteEnable_execute = 1'b1;
    funct3_execute            = 3'b010;
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'h104 || rs2_memory !== 32'h20 || memoryWriteEnable_memory !== 1'b1 ||
        rdWriteEnable_memory !== 1'b0 || funct3_memory !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL store: got alu=%h rs2=%h memWE=%b rdWE=%b f3=%0d, want 00000104/00000020/1/0/2",
               aluResult_memory, rs2_memory, memoryWriteEnable_memory, rdWriteEnable_memory, funct3_memory);
    end
    bypassRS2_execute      = 1'b1;
    bypassValueRS2_execute = 32'h99;
    stepCycle();
    compared++;
    if (rs2_memory !== 32'h99) begin
      mismatched++;
      $display("[TB] FAIL bypass_rs2: got %h want 00000099", rs2_memory);
    end
    clearInputs();
    stepCycle();
  endtask

  task automatic test_mul;
    int stallCycles;
    bit bubbleOk;
    bit timedOut;
    runMulDiv(3'b001, 32'hFFFF_FFFE, 32'd3, stallCycles, bubbleOk, timedOut);
    compared++;
    if (timedOut || stallCycles != 33) begin
      mismatched++;
      $display("[TB] FAIL mulh_stall: got %0d cycles (timeout=%0d) want 33", stallCycles, timedOut);
    end
    compared++;
    if (!bubbleOk) begin
      mismatched++;
      $display("[TB] FAIL mulh_bubble: got non-bubble in memory stage while busy, want bubbles");
    end
    compared++;
    if (aluResult_memory !== 32'hFFFF_FFFF || rdWriteEnable_memory !== 1'b1 || rdAddr_memory !== 5'd5) begin
      mismatched++;
      $display("[TB] FAIL mulh_result: got alu=%h rdWE=%b rd=%0d, want ffffffff/1/5",
               aluResult_memory, rdWriteEnable_memory, rdAddr_memory);
    end
    runMulDiv(3'b000, 32'hFFFF_FFFE, 32'd3, stallCycles, bubbleOk, timedOut);
    compared++;
    if (timedOut || aluResult_memory !== 32'hFFFF_FFFA) begin
      mismatched++;
      $display("[TB] FAIL mul_result: got %h (timeout=%0d) want fffffffa", aluResult_memory, timedOut);
    end
    runMulDiv(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stallCycles, bubbleOk, timedOut);
    compared++;
    if (timedOut || aluResult_memory !== 32'hFFFF_FFFE) begin
      mismatched++;
      $display("[TB] FAIL mulhu_result: got %h (timeout=%0d) want fffffffe", aluResult_memory, timedOut);
    end
    runMulDiv(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stallCycles, bubbleOk, timedOut);
    compared++;
    if (timedOut || aluResult_memory !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("[TB] FAIL mulhsu_result: got %h (timeout=%0d) want ffffffff", aluResult_memory, timedOut);
    end
  endtask

  task automatic test_div;
    logic [2:0]  f3s  [7];
    logic [31:0] as   [7];
    logic [31:0] bs   [7];
    logic [31:0] exps [7];
    int stallCycles;
    bit bubbleOk;
    bit timedOut;
    f3s  = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b111, 3'b100, 3'b110};
    as   = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    bs   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'd2, 32'd2};
    exps = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      runMulDiv(f3s[i], as[i], bs[i], stallCycles, bubbleOk, timedOut);
      compared++;
      if (timedOut || aluResult_memory !== exps[i]) begin
        mismatched++;
        $display("[TB] FAIL div_case%0d: got %h (timeout=%0d) want %h", i, aluResult_memory, timedOut, exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    driveAlu(3'b000, 1'b0, 2'b01, 32'h50, 32'd0, 32'h5);
    stepCycle();
    clearInputs();
    mulDiv_execute        = 1'b1;
    rdWriteEnable_execute = 1'b1;
    rdAddr_execute        = 5'd9;
    funct3_execute        = 3'b000;
    rs1_execute           = 32'd100;
    rs2_execute           = 32'd3;
    repeat (11) stepCycle();
    compared++;
    if (stall_execute !== 1'b1 || aluResult_memory !== 32'h55) begin
      mismatched++;
      $display("[TB] FAIL midrun_busy: got stall=%b alu=%h want 1/00000055", stall_execute, aluResult_memory);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (stall_execute !== 1'b0 || aluResult_memory !== 32'd0 || rdAddr_memory !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got stall=%b alu=%h rd=%0d want 0/0/0",
               stall_execute, aluResult_memory, rdAddr_memory);
    end
    clearInputs();
    @(negedge clock);
    reset = 1'b0;
    stepCycle();
    driveAlu(3'b000, 1'b0, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFD);
    @(negedge clock);
    compared++;
    if (stall_execute !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_stall: got %b want 0", stall_execute);
    end
    stepCycle();
    compared++;
    if (aluResult_memory !== 32'd2 || rdWriteEnable_memory !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL post_reset_add: got alu=%h rdWE=%b want 00000002/1", aluResult_memory, rdWriteEnable_memory);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_add();
    test_shift_lui_auipc();
    test_alu_ops();
    test_bypass();
    test_mul();
    test_div();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
